// File: rtl/ppm_pkg.sv
// Shared definitions for the 4-PPM transmitter.
// Optional feature macro: PPM_GUARD_EN adds a fifth, always-low guard slot to
// every symbol (preamble symbols included).
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } ppm_state_t;

  // Bits carried by one symbol and symbols needed for one byte.
  localparam int PPM_BITS      = 2;
  localparam int SYMS_PER_BYTE = 8 / PPM_BITS;

`ifdef PPM_GUARD_EN
  localparam int SLOTS_PER_SYM = 5;
`else
  localparam int SLOTS_PER_SYM = 4;
`endif

  localparam int SLOT_W = $clog2(SLOTS_PER_SYM);

  localparam int SLOT_CYCLES_DEFAULT   = 4;
  localparam int PREAMBLE_SYMS_DEFAULT = 4;

endpackage

// File: rtl/ppm_symbol_timer.sv
// Slot/symbol timebase: counts cycles within a slot and slots within a
// symbol while run is high, and strobes symbol_end on the last cycle of a
// symbol. slot_next exposes the slot index of the following cycle so the
// parent can register its line output one cycle ahead.
// Optional feature macro: PPM_GUARD_EN (via ppm_pkg::SLOTS_PER_SYM).
module ppm_symbol_timer
  import ppm_pkg::*;
#(
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEFAULT,
  localparam int CYC_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
  input  logic              clk_high,
  input  logic              rst,
  input  logic              run,
  output logic [CYC_W-1:0]  cyc_in_slot,
  output logic [SLOT_W-1:0] slot_in_sym,
  output logic [SLOT_W-1:0] slot_next,
  output logic              symbol_end
);

  logic [CYC_W-1:0] cyc_next;
  logic             cyc_wrap;
  logic             slot_wrap;

  assign cyc_wrap   = (cyc_in_slot == CYC_W'(SLOT_CYCLES - 1));
  assign slot_wrap  = (slot_in_sym == SLOT_W'(SLOTS_PER_SYM - 1));
  assign symbol_end = run & cyc_wrap & slot_wrap;

  // Advance the counters while running; hold them at zero otherwise so the
  // first cycle of a burst always starts at slot 0, cycle 0.
  always_comb begin
    cyc_next  = '0;
    slot_next = '0;
    if (run) begin
      cyc_next  = cyc_wrap ? '0 : cyc_in_slot + 1'b1;
      slot_next = slot_in_sym;
      if (cyc_wrap) begin
        slot_next = slot_wrap ? '0 : slot_in_sym + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_high or negedge rst) begin
    if (!rst) begin
      cyc_in_slot <= '0;
      slot_in_sym <= '0;
    end else begin
      cyc_in_slot <= cyc_next;
      slot_in_sym <= slot_next;
    end
  end

endmodule

// File: rtl/ppm_transmitter.sv
// 4-PPM byte transmitter: one-entry holding buffer, preamble/data FSM and a
// shift register feeding a registered line output. Bytes go out MSB pair
// first; back-to-back bytes follow without gap or repeated preamble.
// Optional feature macro: PPM_GUARD_EN (guard slot per symbol, see ppm_pkg).
module ppm_transmitter
  import ppm_pkg::*;
#(
  parameter int SLOT_CYCLES   = SLOT_CYCLES_DEFAULT,
  parameter int PREAMBLE_SYMS = PREAMBLE_SYMS_DEFAULT
) (
  input  logic       clk_high,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ppmdata,
  output logic       busy
);

  localparam int PSYM_W = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
  localparam int DSYM_W = $clog2(SYMS_PER_BYTE);
  localparam int CYC_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  ppm_state_t          state_reg, state_next;
  logic [7:0]          buf_reg, buf_next;
  logic                buf_full_reg, buf_full_next;
  logic [7:0]          shift_reg, shift_next;
  logic [PSYM_W-1:0]   psym_reg, psym_next;
  logic [DSYM_W-1:0]   dsym_reg, dsym_next;
  logic                ppm_reg, ppm_next;
  logic                ready_en_reg;

  logic                load;
  logic                handshake;
  logic [PPM_BITS-1:0] sym_val;
  logic [CYC_W-1:0]    cyc_in_slot;
  logic [SLOT_W-1:0]   slot_in_sym;
  logic [SLOT_W-1:0]   slot_next;
  logic                symbol_end;

  // ready_en_reg keeps tx_ready low until the first edge after reset release.
  assign tx_ready  = ready_en_reg & ~buf_full_reg;
  assign handshake = tx_valid & tx_ready;
  assign busy      = (state_reg != IDLE);
  assign ppmdata   = ppm_reg;

  ppm_symbol_timer #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_timer (
    .clk_high    (clk_high),
    .rst         (rst),
    .run         (busy),
    .cyc_in_slot (cyc_in_slot),
    .slot_in_sym (slot_in_sym),
    .slot_next   (slot_next),
    .symbol_end  (symbol_end)
  );

  // Next-state, buffer/shift bookkeeping and the look-ahead line value.
  always_comb begin
    state_next    = state_reg;
    buf_next      = buf_reg;
    buf_full_next = buf_full_reg;
    shift_next    = shift_reg;
    psym_next     = psym_reg;
    dsym_next     = dsym_reg;
    load          = 1'b0;
    ppm_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (buf_full_reg) begin
          state_next = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (symbol_end) begin
          if (psym_reg == PSYM_W'(PREAMBLE_SYMS - 1)) begin
            psym_next  = '0;
            state_next = DATA;
            load       = 1'b1;
          end else begin
            psym_next = psym_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (symbol_end) begin
          if (dsym_reg == DSYM_W'(SYMS_PER_BYTE - 1)) begin
            dsym_next = '0;
            if (buf_full_reg) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            dsym_next  = dsym_reg + 1'b1;
            shift_next = shift_reg << PPM_BITS;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A load needs a full buffer and a handshake an empty one, so the two
    // never coincide; a byte offered while the buffer drains waits a cycle.
    if (load) begin
      shift_next    = buf_reg;
      buf_full_next = 1'b0;
    end
    if (handshake) begin
      buf_next      = tx_data;
      buf_full_next = 1'b1;
    end

    // The line is registered, so evaluate the pulse for the coming cycle.
    sym_val = shift_next[7 -: PPM_BITS];
    case (state_next)
      PREAMBLE: ppm_next = (slot_next == '0);
      DATA:     ppm_next = (slot_next == SLOT_W'(sym_val));
      default:  ppm_next = 1'b0;
    endcase
  end

  // State, datapath and line output registers.
  always_ff @(posedge clk_high or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      buf_reg      <= '0;
      buf_full_reg <= 1'b0;
      shift_reg    <= '0;
      psym_reg     <= '0;
      dsym_reg     <= '0;
      ppm_reg      <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      buf_reg      <= buf_next;
      buf_full_reg <= buf_full_next;
      shift_reg    <= shift_next;
      psym_reg     <= psym_next;
      dsym_reg     <= dsym_next;
      ppm_reg      <= ppm_next;
      ready_en_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppm_transmitter.sv
// Randomized bench for ppm_transmitter against a timeline model: every
// accepted byte is turned into absolute pulse/busy cycles from the PPM rules.
module tb_ppm_transmitter;

  localparam int SC   = 4;
  localparam int P    = 4;
`ifdef PPM_GUARD_EN
  localparam int S    = 5;
`else
  localparam int S    = 4;
`endif
  localparam int SYM  = S * SC;
  localparam int NCYC = 8192;
  localparam int NEVER = 1 << 30;

  logic       clk_high = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ppmdata;
  logic       busy;

  always #5 clk_high = ~clk_high;

  ppm_transmitter #(
    .SLOT_CYCLES   (SC),
    .PREAMBLE_SYMS (P)
  ) dut (
    .clk_high (clk_high),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ppmdata  (ppmdata),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;
  int t     = -1;
  int ready_at = NEVER;
  int data_end = 0;
  bit in_reset = 1'b1;

  bit exp_ppm  [NCYC];
  bit exp_busy [NCYC];
  bit obs_ppm  [NCYC];
  bit obs_busy [NCYC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, t);
    end
  endtask

  function automatic bit model_ready(input int tc);
    return !in_reset && (tc >= ready_at);
  endfunction

  task automatic mark_pulse(input int s);
    for (int i = 0; i < SC; i++) if (s + i < NCYC) exp_ppm[s + i] = 1'b1;
  endtask

  task automatic mark_busy(input int s, input int n);
    for (int i = 0; i < n; i++) if (s + i < NCYC) exp_busy[s + i] = 1'b1;
  endtask

  // Schedule one accepted byte. It chains onto the running byte if it was
  // buffered by that byte's second-to-last cycle; otherwise it gets a preamble
  // whose first pulse is two cycles after the handshake.
  task automatic model_accept(input int tc, input logic [7:0] b);
    int d;
    int p;
    int v;
    if (tc <= data_end - 2) begin
      d = data_end;
    end else begin
      p = tc + 2;
      for (int i = 0; i < P; i++) mark_pulse(p + i * SYM);
      mark_busy(p, P * SYM);
      d = p + P * SYM;
    end
    for (int k = 0; k < 4; k++) begin
      v = (b >> (6 - 2 * k)) & 3;
      mark_pulse(d + k * SYM + v * SC);
    end
    mark_busy(d, 4 * SYM);
    data_end = d + 4 * SYM;
    ready_at = d;
  endtask

  task automatic model_clear(input int from);
    for (int c = from; c < NCYC; c++) begin
      exp_ppm[c]  = 1'b0;
      exp_busy[c] = 1'b0;
    end
    data_end = 0;
    ready_at = NEVER;
  endtask

  // One cycle: check outputs at the falling edge, then drive inputs.
  task automatic tick(input logic v, input logic [7:0] d, output bit acc);
    @(negedge clk_high);
    t++;
    obs_ppm[t]  = ppmdata;
    obs_busy[t] = busy;
    check("ppmdata", ppmdata, exp_ppm[t]);
    check("busy", busy, exp_busy[t]);
    check("tx_ready", tx_ready, model_ready(t));
    tx_valid = v;
    tx_data  = d;
    acc = v && model_ready(t);
    if (acc) begin
      model_accept(t, d);
      $display("cycle %0d: accepted byte 0x%02h", t, d);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, a);
  endtask

  // Assert reset at a falling edge, hold for n cycles, then release.
  task automatic do_reset(input int n);
    bit a;
    @(negedge clk_high);
    t++;
    rst      = 1'b0;
    in_reset = 1'b1;
    tx_valid = 1'b0;
    model_clear(t);
    #1;
    obs_ppm[t]  = ppmdata;
    obs_busy[t] = busy;
    check("rst_ppmdata", ppmdata, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 0);
    $display("cycle %0d: reset asserted for %0d cycles", t, n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, a);
    rst      = 1'b1;
    in_reset = 1'b0;
    ready_at = t + 1;
  endtask

  task automatic send_held(input logic [7:0] b, output int hc);
    bit a;
    int n;
    a  = 1'b0;
    n  = 0;
    hc = -1;
    while (!a && n < 500) begin
      tick(1'b1, b, a);
      n++;
    end
    if (a) hc = t;
    else check("accept_timeout", 0, 1);
  endtask

  initial begin
    int h;
    int h1;
    int h2;
    int d;
    int lows;
    bit a;

    // Power-up in reset.
    in_reset = 1'b1;
    ready_at = NEVER;
    idle(3);
    rst      = 1'b1;
    in_reset = 1'b0;
    ready_at = t + 1;

    // Quiet line with no traffic.
    idle(100);

    // Single byte 0xB4.
    send_held(8'hB4, h);
    idle(170);
    if (h >= 0) begin
      check("pre0_start", obs_ppm[h + 2], 1);
      check("pre0_end", obs_ppm[h + 5], 1);
      check("pre0_after", obs_ppm[h + 6], 0);
      check("busy_before", obs_busy[h + 1], 0);
      check("busy_start", obs_busy[h + 2], 1);
`ifdef PPM_GUARD_EN
      check("pre1", obs_ppm[h + 22], 1);
      check("pre2", obs_ppm[h + 42], 1);
      check("pre3", obs_ppm[h + 62], 1);
      check("d0_slot2", obs_ppm[h + 90], 1);
      check("d1_slot3", obs_ppm[h + 117], 1);
      check("d1_guard_a", obs_ppm[h + 118], 0);
      check("d1_guard_b", obs_ppm[h + 121], 0);
      check("d2_slot1", obs_ppm[h + 126], 1);
      check("busy_last", obs_busy[h + 161], 1);
      check("busy_fall", obs_busy[h + 162], 0);
`else
      check("pre1", obs_ppm[h + 18], 1);
      check("pre2", obs_ppm[h + 34], 1);
      check("pre3", obs_ppm[h + 50], 1);
      check("d0_slot2", obs_ppm[h + 74], 1);
      check("d0_before", obs_ppm[h + 73], 0);
      check("d1_slot3", obs_ppm[h + 94], 1);
      check("d2_slot1", obs_ppm[h + 102], 1);
      check("d3_slot0", obs_ppm[h + 114], 1);
      check("d3_after", obs_ppm[h + 118], 0);
      check("busy_last", obs_busy[h + 129], 1);
      check("busy_fall", obs_busy[h + 130], 0);
`endif
    end

    // Back-to-back 0x00 then 0xFF with tx_valid held.
    send_held(8'h00, h1);
    send_held(8'hFF, h2);
    idle(20 * SYM);
    if (h1 >= 0) begin
      d = h1 + 2 + P * SYM;
      check("chain_b0_slot0", obs_ppm[d], 1);
      check("chain_b1_slot3", obs_ppm[d + 4 * SYM + 3 * SC], 1);
      check("chain_b1_slot0", obs_ppm[d + 4 * SYM], 0);
      lows = 0;
      for (int c = h1 + 2; c < d + 8 * SYM; c++) if (!obs_busy[c]) lows++;
      check("chain_busy_gaps", lows, 0);
    end

    // Reset in the middle of a byte, then a fresh byte 0x1E.
    send_held(8'hB4, h);
    while (t < h + 79) tick(1'b0, 8'h00, a);
    do_reset(3);
    send_held(8'h1E, h);
    idle(10 * SYM);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 4));
      end else begin
        tick($urandom_range(0, 3) != 0, 8'($urandom), a);
      end
    end
    idle(15 * SYM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
